mem_arbiter: RTL and testbench

Two-requester Wishbone arbiter that shares a single `mem_byte` data memory between the instruction-fetch port (m0) and the load/store port (m1) of the core. It latches the winning request and drives it to the memory's slave port. It routes `wb_ack_o`/`wb_dat_o` back only to the granted requester, and alternates grants round-robin on contention. It sits between the core's bus ports and `mem_byte` in the wrapper.

---
 rtl/mem_arbiter_if.sv | 26 ++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Wishbone-style request/response bundle between a requester and a responder.
// The master modport belongs to whoever issues the request; slave to whoever answers it.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] wdat;
    logic                  we;
    logic                  stb;
    logic                  cyc;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] rdat;
    logic                  ack;
    logic                  err;

    modport master (
        output adr, wdat, we, stb, cyc, funct3,
        input  rdat, ack, err
    );

    modport slave (
        input  adr, wdat, we, stb, cyc, funct3,
        output rdat, ack, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of mem_byte (m0 = fetch, m1 = load/store).
// Define MEM_ARB_TIMEOUT_EN to abort a transaction with an err pulse after TIMEOUT_CYCLES unacked BUSY cycles.
module mem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 7,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   m0,
    mem_arbiter_if.slave   m1,
    mem_arbiter_if.master  s
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  last_gnt_q, last_gnt_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;

    logic req0, req1, winner, busy, timeout_hit;
    logic unused_sig;

    assign req0 = m0.stb & m0.cyc;
    assign req1 = m1.stb & m1.cyc;
    assign busy = (state_q == ST_BUSY);
    // On a tie the requester that was not served last wins
    assign winner = (req0 & req1) ? ~last_gnt_q : req1;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (busy && !s.ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // An ack arriving in the expiry cycle takes priority over the timeout
    assign timeout_hit = busy && !s.ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    gnt_d    = winner;
                    adr_d    = winner ? m1.adr    : m0.adr;
                    dat_d    = winner ? m1.wdat   : m0.wdat;
                    we_d     = winner ? m1.we     : m0.we;
                    funct3_d = winner ? m1.funct3 : m0.funct3;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s.ack || timeout_hit) begin
                    last_gnt_d = gnt_q;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            adr_q      <= '0;
            dat_q      <= '0;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
        end
    end

    // Slave side is quiet outside BUSY so the GAP cycle lets mem_byte drop its ack
    assign s.stb    = busy;
    assign s.cyc    = busy;
    assign s.adr    = busy ? adr_q    : '0;
    assign s.wdat   = busy ? dat_q    : '0;
    assign s.we     = busy & we_q;
    assign s.funct3 = busy ? funct3_q : 3'b000;

    // Responses are gated by rst so an ack racing a reset never reaches a requester
    assign m0.ack  = busy & ~gnt_q & s.ack & ~rst;
    assign m1.ack  = busy &  gnt_q & s.ack & ~rst;
    assign m0.err  = busy & ~gnt_q & timeout_hit & ~rst;
    assign m1.err  = busy &  gnt_q & timeout_hit & ~rst;
    assign m0.rdat = s.rdat;
    assign m1.rdat = s.rdat;

    assign unused_sig = s.err | (TIMEOUT_CYCLES < 2);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand sequences for
// early drop, long stall / timeout and reset during BUSY.
module tb_mem_arbiter;
    localparam logic [6:0]  A0 = 7'h04;
    localparam logic [6:0]  A1 = 7'h08;
    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'h2222_2222;
    localparam logic [2:0]  F0 = 3'b010;
    localparam logic [2:0]  F1 = 3'b100;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) m0_bus ();
    mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) m1_bus ();
    mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) s_bus ();

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .TIMEOUT_CYCLES(15)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .s   (s_bus)
    );

    typedef struct {
        logic        rst;
        logic        r0;
        logic [6:0]  a0;
        logic        w0;
        logic [31:0] d0;
        logic [2:0]  f0;
        logic        r1;
        logic [6:0]  a1;
        logic        w1;
        logic [31:0] d1;
        logic [2:0]  f1;
        logic        sack;
        logic [31:0] sdat;
        logic        chk;
        logic        estb;
        logic [6:0]  eadr;
        logic        ewe;
        logic [31:0] edat;
        logic [2:0]  ef3;
        logic        ea0;
        logic        ea1;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t v(
        input logic rst_v, input logic r0, input logic [6:0] a0, input logic w0,
        input logic [31:0] d0, input logic [2:0] f0,
        input logic r1, input logic [6:0] a1, input logic w1,
        input logic [31:0] d1, input logic [2:0] f1,
        input logic sack, input logic [31:0] sdat, input logic chk,
        input logic estb, input logic [6:0] eadr, input logic ewe,
        input logic [31:0] edat, input logic [2:0] ef3, input logic ea0, input logic ea1);
        vec_t t;
        t.rst = rst_v; t.r0 = r0; t.a0 = a0; t.w0 = w0; t.d0 = d0; t.f0 = f0;
        t.r1 = r1; t.a1 = a1; t.w1 = w1; t.d1 = d1; t.f1 = f1;
        t.sack = sack; t.sdat = sdat; t.chk = chk;
        t.estb = estb; t.eadr = eadr; t.ewe = ewe; t.edat = edat; t.ef3 = ef3;
        t.ea0 = ea0; t.ea1 = ea1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic set_m0(input logic r, input logic [6:0] a);
        m0_bus.stb = r; m0_bus.cyc = r; m0_bus.adr = a;
        m0_bus.we = 1'b0; m0_bus.wdat = D0; m0_bus.funct3 = F0;
    endtask

    task automatic set_m1(input logic r, input logic [6:0] a);
        m1_bus.stb = r; m1_bus.cyc = r; m1_bus.adr = a;
        m1_bus.we = 1'b0; m1_bus.wdat = D1; m1_bus.funct3 = F1;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_stb"},   {31'd0, s_bus.stb},  32'd0);
        chk({tag, "_m0ack"}, {31'd0, m0_bus.ack}, 32'd0);
        chk({tag, "_m1ack"}, {31'd0, m1_bus.ack}, 32'd0);
    endtask

    initial begin
        // Reset with both requesting, then contention m0/m1/m0/m1
        tbl[0]  = v(1, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 0,32'h0,         0, 0,7'h0,0,32'h0,3'b0, 0,0);
        tbl[1]  = v(1, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 0,32'h0,         1, 0,7'h0,0,32'h0,3'b0, 0,0);
        tbl[2]  = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 0,32'h0,         1, 0,7'h0,0,32'h0,3'b0, 0,0);
        tbl[3]  = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 0,32'h0,         1, 1,A0,  0,D0,   F0,   0,0);
        tbl[4]  = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 1,32'hA0A0_A0A0, 1, 1,A0,  0,D0,   F0,   1,0);
        tbl[5]  = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 0,32'h0,         1, 0,7'h0,0,32'h0,3'b0, 0,0);
        tbl[6]  = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 0,32'h0,         1, 0,7'h0,0,32'h0,3'b0, 0,0);
        tbl[7]  = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 0,32'h0,         1, 1,A1,  0,D1,   F1,   0,0);
        tbl[8]  = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 1,32'hB1B1_B1B1, 1, 1,A1,  0,D1,   F1,   0,1);
        tbl[9]  = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 0,32'h0,         1, 0,7'h0,0,32'h0,3'b0, 0,0);
        tbl[10] = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 0,32'h0,         1, 0,7'h0,0,32'h0,3'b0, 0,0);
        tbl[11] = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 0,32'h0,         1, 1,A0,  0,D0,   F0,   0,0);
        tbl[12] = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 1,32'hC2C2_C2C2, 1, 1,A0,  0,D0,   F0,   1,0);
        tbl[13] = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 0,32'h0,         1, 0,7'h0,0,32'h0,3'b0, 0,0);
        tbl[14] = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 0,32'h0,         1, 0,7'h0,0,32'h0,3'b0, 0,0);
        tbl[15] = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 0,32'h0,         1, 1,A1,  0,D1,   F1,   0,0);
        tbl[16] = v(0, 1,A0,0,D0,F0, 1,A1,0,D1,F1, 1,32'hD3D3_D3D3, 1, 1,A1,  0,D1,   F1,   0,1);
        // m1 lone write, then stray acks in GAP and IDLE
        tbl[17] = v(0, 0,A0,0,D0,F0, 0,A1,0,D1,F1, 0,32'h0,         1, 0,7'h0,0,32'h0,3'b0, 0,0);
        tbl[18] = v(0, 0,A0,0,D0,F0, 1,7'h10,1,32'hDEAD_BEEF,3'b010, 0,32'h0, 1, 0,7'h0,0,32'h0,3'b0, 0,0);
        tbl[19] = v(0, 0,A0,0,D0,F0, 1,7'h10,1,32'hDEAD_BEEF,3'b010, 0,32'h0, 1, 1,7'h10,1,32'hDEAD_BEEF,3'b010, 0,0);
        tbl[20] = v(0, 0,A0,0,D0,F0, 1,7'h10,1,32'hDEAD_BEEF,3'b010, 1,32'h0, 1, 1,7'h10,1,32'hDEAD_BEEF,3'b010, 0,1);
        tbl[21] = v(0, 0,A0,0,D0,F0, 0,A1,0,D1,F1, 1,32'h5555_0000, 1, 0,7'h0,0,32'h0,3'b0, 0,0);
        tbl[22] = v(0, 0,A0,0,D0,F0, 0,A1,0,D1,F1, 1,32'h5555_0001, 1, 0,7'h0,0,32'h0,3'b0, 0,0);
        tbl[23] = v(0, 0,A0,0,D0,F0, 0,A1,0,D1,F1, 0,32'h0,         1, 0,7'h0,0,32'h0,3'b0, 0,0);

        s_bus.err = 1'b0;
        for (int i = 0; i < 24; i++) begin
            rst = tbl[i].rst;
            m0_bus.stb = tbl[i].r0; m0_bus.cyc = tbl[i].r0; m0_bus.adr = tbl[i].a0;
            m0_bus.we = tbl[i].w0; m0_bus.wdat = tbl[i].d0; m0_bus.funct3 = tbl[i].f0;
            m1_bus.stb = tbl[i].r1; m1_bus.cyc = tbl[i].r1; m1_bus.adr = tbl[i].a1;
            m1_bus.we = tbl[i].w1; m1_bus.wdat = tbl[i].d1; m1_bus.funct3 = tbl[i].f1;
            s_bus.ack = tbl[i].sack; s_bus.rdat = tbl[i].sdat;
            smp;
            if (tbl[i].chk) begin
                $display("row %0d: stb=%b adr=%h we=%b dat=%h f3=%b ack0=%b ack1=%b",
                         i, s_bus.stb, s_bus.adr, s_bus.we, s_bus.wdat, s_bus.funct3,
                         m0_bus.ack, m1_bus.ack);
                chk($sformatf("row%0d_stb", i),   {31'd0, s_bus.stb},   {31'd0, tbl[i].estb});
                chk($sformatf("row%0d_cyc", i),   {31'd0, s_bus.cyc},   {31'd0, tbl[i].estb});
                chk($sformatf("row%0d_adr", i),   {25'd0, s_bus.adr},   {25'd0, tbl[i].eadr});
                chk($sformatf("row%0d_we", i),    {31'd0, s_bus.we},    {31'd0, tbl[i].ewe});
                chk($sformatf("row%0d_dat", i),   s_bus.wdat,           tbl[i].edat);
                chk($sformatf("row%0d_f3", i),    {29'd0, s_bus.funct3},{29'd0, tbl[i].ef3});
                chk($sformatf("row%0d_m0ack", i), {31'd0, m0_bus.ack},  {31'd0, tbl[i].ea0});
                chk($sformatf("row%0d_m1ack", i), {31'd0, m1_bus.ack},  {31'd0, tbl[i].ea1});
                chk($sformatf("row%0d_m0err", i), {31'd0, m0_bus.err},  32'd0);
                chk($sformatf("row%0d_m1err", i), {31'd0, m1_bus.err},  32'd0);
                if (tbl[i].ea0) chk($sformatf("row%0d_m0dat", i), m0_bus.rdat, tbl[i].sdat);
                if (tbl[i].ea1) chk($sformatf("row%0d_m1dat", i), m1_bus.rdat, tbl[i].sdat);
            end
            nxt;
        end

        // Early drop: m0 releases stb right after grant, held copy completes
        set_m0(1'b1, 7'h20); set_m1(1'b0, A1); s_bus.ack = 1'b0;
        smp; check_quiet("ed_idle"); nxt;
        set_m0(1'b0, 7'h3F);
        for (int k = 0; k < 2; k++) begin
            smp;
            chk("ed_stb", {31'd0, s_bus.stb}, 32'd1);
            chk("ed_adr", {25'd0, s_bus.adr}, 32'h20);
            nxt;
        end
        s_bus.ack = 1'b1; s_bus.rdat = 32'h5A5A_5A5A;
        smp;
        $display("early drop ack: adr=%h ack0=%b dat=%h", s_bus.adr, m0_bus.ack, m0_bus.rdat);
        chk("ed_adr_ack", {25'd0, s_bus.adr}, 32'h20);
        chk("ed_m0ack", {31'd0, m0_bus.ack}, 32'd1);
        chk("ed_m0dat", m0_bus.rdat, 32'h5A5A_5A5A);
        nxt;
        s_bus.ack = 1'b0;
        smp; check_quiet("ed_gap"); nxt;

        // Long stall on m0 with m1 pending behind it
        set_m0(1'b1, 7'h24);
        smp; nxt;
        set_m1(1'b1, 7'h28);
`ifdef MEM_ARB_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            smp;
            chk($sformatf("to_stb_%0d", k), {31'd0, s_bus.stb}, 32'd1);
            chk($sformatf("to_adr_%0d", k), {25'd0, s_bus.adr}, 32'h24);
            chk($sformatf("to_m0err_%0d", k), {31'd0, m0_bus.err}, (k == 15) ? 32'd1 : 32'd0);
            chk($sformatf("to_m1err_%0d", k), {31'd0, m1_bus.err}, 32'd0);
            chk($sformatf("to_m0ack_%0d", k), {31'd0, m0_bus.ack}, 32'd0);
            nxt;
        end
        $display("timeout: m0 err pulsed after 15 busy cycles");
        set_m0(1'b0, 7'h24);
        smp; check_quiet("to_gap"); chk("to_gap_err", {31'd0, m0_bus.err}, 32'd0); nxt;
`else
        for (int k = 1; k <= 20; k++) begin
            smp;
            chk($sformatf("st_stb_%0d", k), {31'd0, s_bus.stb}, 32'd1);
            chk($sformatf("st_m0err_%0d", k), {31'd0, m0_bus.err}, 32'd0);
            chk($sformatf("st_m0ack_%0d", k), {31'd0, m0_bus.ack}, 32'd0);
            nxt;
        end
        s_bus.ack = 1'b1; s_bus.rdat = 32'h0BAD_F00D;
        smp;
        $display("stall: m0 acked after 20 busy cycles ack0=%b", m0_bus.ack);
        chk("st_m0ack", {31'd0, m0_bus.ack}, 32'd1);
        chk("st_m1ack", {31'd0, m1_bus.ack}, 32'd0);
        nxt;
        s_bus.ack = 1'b0; set_m0(1'b0, 7'h24);
        smp; check_quiet("st_gap"); nxt;
`endif
        smp; check_quiet("pend_idle"); nxt;
        smp;
        chk("pend_stb", {31'd0, s_bus.stb}, 32'd1);
        chk("pend_adr", {25'd0, s_bus.adr}, 32'h28);
        nxt;
        s_bus.ack = 1'b1; s_bus.rdat = 32'h7777_8888;
        smp;
        $display("pending m1 served: ack1=%b dat=%h", m1_bus.ack, m1_bus.rdat);
        chk("pend_m1ack", {31'd0, m1_bus.ack}, 32'd1);
        chk("pend_m0ack", {31'd0, m0_bus.ack}, 32'd0);
        nxt;
        s_bus.ack = 1'b0; set_m1(1'b0, 7'h28);
        smp; nxt;

        // Reset asserted in the same cycle the slave acks
        set_m0(1'b1, 7'h30);
        smp; nxt;
        smp; chk("rb_stb", {31'd0, s_bus.stb}, 32'd1); nxt;
        rst = 1'b1; s_bus.ack = 1'b1;
        smp;
        chk("rb_m0ack", {31'd0, m0_bus.ack}, 32'd0);
        chk("rb_m1ack", {31'd0, m1_bus.ack}, 32'd0);
        nxt;
        rst = 1'b0; s_bus.ack = 1'b0; set_m0(1'b0, 7'h30);
        smp;
        $display("after reset: stb=%b adr=%h ack0=%b", s_bus.stb, s_bus.adr, m0_bus.ack);
        check_quiet("rb_after");
        chk("rb_adr", {25'd0, s_bus.adr}, 32'd0);
        chk("rb_m0err", {31'd0, m0_bus.err}, 32'd0);
        nxt;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
